rr_grant_arbiter: RTL and testbench



---
 rtl/rr_arb_pkg.sv | 14 +
 rtl/rr_grant_arbiter_if.sv | 31 +++
 rtl/rr_grant_arbiter_pick.sv | 49 ++++
 rtl/rr_grant_arbiter.sv | 137 +++++++++++++
 tb/tb_rr_grant_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and sizing helpers for the round-robin grant arbiter.
// The optional hold timeout in the top is enabled by defining ARB_TIMEOUT_EN.
package rr_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

   localparam int RR_DEFAULT_N = 8;

   // Index width for n requesters; never narrower than one bit.
   function automatic int rr_idw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Bundle of request/grant signals between the requesters and the arbiter.
interface rr_grant_arbiter_if
   import rr_arb_pkg::*;
#(
   parameter int N   = RR_DEFAULT_N,
   parameter int IDW = rr_idw(N)
) ();

   // Handshake: req is a level held by each requester. gnt/gnt_id/gnt_valid
   // change only on a clock edge and stay stable while a grant is owned. The
   // owner ends its grant with a one-cycle rel pulse. The arbiter may instead
   // end it with a forced release, flagged by a one-cycle timeout pulse.
   logic [N-1:0]   req;
   logic           rel;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] gnt_id;
   logic           gnt_valid;
   logic           timeout;
   arb_state_t     state;

   modport slave (
      input  req, rel,
      output gnt, gnt_id, gnt_valid, timeout, state
   );

   modport master (
      output req, rel,
      input  gnt, gnt_id, gnt_valid, timeout, state
   );

endinterface

// File: rtl/rr_grant_arbiter_pick.sv
// Combinational round-robin winner search: the lowest request above last_id,
// falling back to the lowest request overall.
module rr_pick
   import rr_arb_pkg::*;
#(
   parameter int N   = RR_DEFAULT_N,
   parameter int IDW = rr_idw(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] last_id,
   output logic [IDW-1:0] winner,
   output logic           found
);

   logic [N-1:0]   mask;
   logic [N-1:0]   masked_req;
   logic [IDW-1:0] masked_id;
   logic           masked_hit;
   logic [IDW-1:0] plain_id;

   always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (i > int'(last_id));
      end
   end

   assign masked_req = req & mask;

   // Scanning from the top down leaves the lowest set index in the result.
   always_comb begin
      masked_id  = '0;
      masked_hit = 1'b0;
      plain_id   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (masked_req[i]) begin
            masked_id  = IDW'(i);
            masked_hit = 1'b1;
         end
         if (req[i]) begin
            plain_id = IDW'(i);
         end
      end
   end

   assign found  = |req;
   assign winner = masked_hit ? masked_id : plain_id;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter: grants are held until rel, re-arbitrated on
// the release edge. Define ARB_TIMEOUT_EN to force release after MAX_HOLD cycles.
module rr_grant_arbiter
   import rr_arb_pkg::*;
#(
   parameter int N        = RR_DEFAULT_N,
   parameter int IDW      = rr_idw(N),
   parameter int MAX_HOLD = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   rr_grant_arbiter_if.slave  bus
);

   arb_state_t     state_q, state_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic [IDW-1:0] gnt_id_q, gnt_id_d;
   logic           gnt_valid_q, gnt_valid_d;
   logic [IDW-1:0] last_id_q, last_id_d;

   logic [IDW-1:0] pick_id;
   logic           pick_found;
   logic           load;
   logic           forced;
   logic           release_now;

   rr_pick #(
      .N   (N),
      .IDW (IDW)
   ) u_pick (
      .req     (bus.req),
      .last_id (last_id_q),
      .winner  (pick_id),
      .found   (pick_found)
   );

   assign release_now = bus.rel | forced;

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = gnt_valid_q;
      last_id_d   = last_id_q;
      load        = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            if (pick_found) begin
               load = 1'b1;
            end
         end
         ARB_BUSY: begin
            if (release_now) begin
               if (pick_found) begin
                  load = 1'b1;
               end else begin
                  // gnt_id deliberately keeps the last owner while idle.
                  state_d     = ARB_IDLE;
                  gnt_d       = '0;
                  gnt_valid_d = 1'b0;
               end
            end
         end
      endcase

      if (load) begin
         state_d     = ARB_BUSY;
         gnt_d       = {{(N-1){1'b0}}, 1'b1} << pick_id;
         gnt_id_d    = pick_id;
         gnt_valid_d = 1'b1;
         last_id_d   = pick_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB_IDLE;
         gnt_q       <= '0;
         gnt_id_q    <= '0;
         gnt_valid_q <= 1'b0;
         last_id_q   <= IDW'(N - 1);
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
         last_id_q   <= last_id_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   logic [HW-1:0] hold_q, hold_d;
   logic          timeout_q, timeout_d;

   // An owner's own rel on the limit cycle wins: that is a normal release.
   assign forced = (state_q == ARB_BUSY) && !bus.rel && (hold_q == HW'(MAX_HOLD - 1));

   always_comb begin
      hold_d    = hold_q;
      timeout_d = forced;
      if (load) begin
         hold_d = '0;
      end else if (state_q == ARB_BUSY) begin
         hold_d = hold_q + 1'b1;
      end else begin
         hold_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.timeout = timeout_q;
`else
   logic unused_hold;

   assign unused_hold = (MAX_HOLD > 0);
   assign forced      = 1'b0;
   assign bus.timeout = 1'b0;
`endif

   assign bus.gnt       = gnt_q;
   assign bus.gnt_id    = gnt_id_q;
   assign bus.gnt_valid = gnt_valid_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter: directed scenarios plus random
// traffic against a cyclic-search reference model (ARB_TIMEOUT_EN aware).
module tb_rr_grant_arbiter;
  import rr_arb_pkg::*;

  localparam int N        = 8;
  localparam int IDW      = 3;
  localparam int MAX_HOLD = 4;
  localparam int VW       = N + IDW + 2;

  logic clk;
  logic rst_n;
  int   check_cnt;
  int   pass_cnt;

  // reference model state
  logic m_valid;
  int   m_owner;
  int   m_last;
  int   m_held;
  logic m_timeout;

  rr_grant_arbiter_if #(.N(N), .IDW(IDW)) bus ();

  rr_grant_arbiter #(
    .N        (N),
    .IDW      (IDW),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic void model_reset();
    m_valid   = 1'b0;
    m_owner   = 0;
    m_last    = N - 1;
    m_held    = 0;
    m_timeout = 1'b0;
  endfunction

  function automatic void model_grant(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (r[idx]) begin
        m_owner = idx;
        m_last  = idx;
        m_valid = 1'b1;
        m_held  = 0;
        return;
      end
    end
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input logic l);
    logic frc;
    frc = 1'b0;
`ifdef ARB_TIMEOUT_EN
    frc = m_valid && !l && (m_held == MAX_HOLD - 1);
`endif
    m_timeout = frc;
    if (!m_valid) begin
      if (r != '0) model_grant(r);
    end else if (l || frc) begin
      if (r != '0) model_grant(r);
      else m_valid = 1'b0;
    end else begin
      m_held++;
    end
  endfunction

  function automatic logic [VW-1:0] pack(input int id, input logic v, input logic t);
    logic [N-1:0] g;
    g = v ? (N'(1) << id) : '0;
    return {g, IDW'(id), v, t};
  endfunction

  function automatic logic [VW-1:0] obs();
    return {bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [N-1:0] r, input logic l);
    bus.req = r;
    bus.rel = l;
  endtask

  // Called at posedge+1; returns at the next posedge+1 with the model advanced.
  task automatic cycle();
    logic [N-1:0] r;
    logic         l;
    r = bus.req;
    l = bus.rel;
    @(posedge clk);
    model_step(r, l);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive('0, 1'b0);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    drive('0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_cnt++;
    if (obs() !== pack(0, 1'b0, 1'b0) || bus.state !== ARB_IDLE) begin
      $display("FAIL reset_state: got %h state %0d want %h state 0", obs(), bus.state, pack(0, 1'b0, 1'b0));
    end else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_first_grant();
    drive(8'b0000_0101, 1'b0);
    cycle();
    check_cnt++;
    if (obs() !== pack(0, 1'b1, 1'b0)) begin
      $display("FAIL first_grant: got %h want %h", obs(), pack(0, 1'b1, 1'b0));
    end else pass_cnt++;
    drive(8'b0000_0101, 1'b1);
    cycle();
    check_cnt++;
    if (obs() !== pack(2, 1'b1, 1'b0)) begin
      $display("FAIL back_to_back: got %h want %h", obs(), pack(2, 1'b1, 1'b0));
    end else pass_cnt++;
  endtask

  task automatic test_idle_paths();
    drive('0, 1'b1);
    cycle();
    check_cnt++;
    if (obs() !== pack(2, 1'b0, 1'b0) || bus.state !== ARB_IDLE) begin
      $display("FAIL rel_to_idle: got %h state %0d want %h state 0", obs(), bus.state, pack(2, 1'b0, 1'b0));
    end else pass_cnt++;
    drive('0, 1'b1);
    cycle();
    drive('0, 1'b0);
    cycle();
    check_cnt++;
    if (obs() !== pack(2, 1'b0, 1'b0) || bus.state !== ARB_IDLE) begin
      $display("FAIL rel_in_idle: got %h state %0d want %h state 0", obs(), bus.state, pack(2, 1'b0, 1'b0));
    end else pass_cnt++;
  endtask

  task automatic test_fairness();
    do_reset();
    drive(8'hFF, 1'b0);
    cycle();
    check_cnt++;
    if (obs() !== pack(0, 1'b1, 1'b0)) begin
      $display("FAIL fair_first: got %h want %h", obs(), pack(0, 1'b1, 1'b0));
    end else pass_cnt++;
    for (int k = 1; k <= N; k++) begin
      drive(8'hFF, 1'b1);
      cycle();
      check_cnt++;
      if (obs() !== pack(k % N, 1'b1, 1'b0)) begin
        $display("FAIL fair_step%0d: got %h want %h", k, obs(), pack(k % N, 1'b1, 1'b0));
      end else pass_cnt++;
      drive(8'hFF, 1'b0);
      cycle();
      check_cnt++;
      if (obs() !== pack(k % N, 1'b1, 1'b0)) begin
        $display("FAIL fair_hold%0d: got %h want %h", k, obs(), pack(k % N, 1'b1, 1'b0));
      end else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(8'b0100_0000, 1'b0);
    cycle();
    drive(8'b1000_0010, 1'b1);
    cycle();
    check_cnt++;
    if (obs() !== pack(7, 1'b1, 1'b0)) begin
      $display("FAIL wrap_to_7: got %h want %h", obs(), pack(7, 1'b1, 1'b0));
    end else pass_cnt++;
    cycle();
    check_cnt++;
    if (obs() !== pack(1, 1'b1, 1'b0)) begin
      $display("FAIL wrap_to_1: got %h want %h", obs(), pack(1, 1'b1, 1'b0));
    end else pass_cnt++;
  endtask

  task automatic test_sole_requester();
    do_reset();
    drive(8'b0000_1000, 1'b0);
    cycle();
    drive(8'b0000_1000, 1'b1);
    cycle();
    check_cnt++;
    if (obs() !== pack(3, 1'b1, 1'b0) || bus.state !== ARB_BUSY) begin
      $display("FAIL sole_regrant: got %h want %h", obs(), pack(3, 1'b1, 1'b0));
    end else pass_cnt++;
  endtask

  task automatic test_withdraw();
    do_reset();
    drive(8'b0000_0100, 1'b0);
    cycle();
    drive(8'b0001_0000, 1'b0);
    cycle();
    cycle();
    check_cnt++;
    if (obs() !== pack(2, 1'b1, 1'b0)) begin
      $display("FAIL withdraw_hold: got %h want %h", obs(), pack(2, 1'b1, 1'b0));
    end else pass_cnt++;
    drive('0, 1'b1);
    cycle();
    check_cnt++;
    if (obs() !== pack(2, 1'b0, 1'b0)) begin
      $display("FAIL withdraw_release: got %h want %h", obs(), pack(2, 1'b0, 1'b0));
    end else pass_cnt++;
  endtask

  task automatic test_timeout();
    logic [VW-1:0] want;
    do_reset();
    drive(8'b0000_0011, 1'b0);
    cycle();
    for (int k = 1; k <= 6; k++) begin
      cycle();
`ifdef ARB_TIMEOUT_EN
      want = (k < 4) ? pack(0, 1'b1, 1'b0) : pack(1, 1'b1, (k == 4));
`else
      want = pack(0, 1'b1, 1'b0);
`endif
      check_cnt++;
      if (obs() !== want) begin
        $display("FAIL timeout_cyc%0d: got %h want %h", k, obs(), want);
      end else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(8'b0010_0000, 1'b0);
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_cnt++;
    if (obs() !== pack(0, 1'b0, 1'b0) || bus.state !== ARB_IDLE) begin
      $display("FAIL async_reset: got %h state %0d want %h state 0", obs(), bus.state, pack(0, 1'b0, 1'b0));
    end else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    drive('0, 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      drive(r, ($urandom_range(0, 9) < 4));
      cycle();
      check_cnt++;
      if (obs() !== pack(m_owner, m_valid, m_timeout) ||
          bus.state !== (m_valid ? ARB_BUSY : ARB_IDLE)) begin
        $display("FAIL random_c%0d: got %h want %h", c, obs(), pack(m_owner, m_valid, m_timeout));
      end else pass_cnt++;
      check_cnt++;
      if ($countones(bus.gnt) > 1 || bus.gnt[bus.gnt_id] !== bus.gnt_valid) begin
        $display("FAIL onehot_c%0d: got gnt %b id %0d valid %b", c, bus.gnt, bus.gnt_id, bus.gnt_valid);
      end else pass_cnt++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    check_cnt = 0;
    pass_cnt  = 0;
    model_reset();
    test_reset();
    test_first_grant();
    test_idle_paths();
    test_fairness();
    test_wrap();
    test_sole_requester();
    test_withdraw();
    test_timeout();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
